// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch-stage state encoding and default reset PC
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FULL = 2'd2, DRAIN = 2'd3} state_t;
  localparam int unsigned RESET_PC_DEFAULT = 0;
endpackage

// File: rtl/fetch_stage_pc_counter.sv
// pc_counter: program counter with priority load over increment
module pc_counter
  import fetch_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] d,
  output logic [W-1:0] pc
);
  always_ff @(posedge clk or posedge rst)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= d;
    else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with stall and redirect flush
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  input  logic                   id_ready,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc
);
  state_t state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_next, req_addr, addr_n, ipc_n;
  logic [INSTR_WIDTH-1:0] instr_n;
  logic valid_n, inc;
  pc_counter #(.W(PC_WIDTH), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(redirect_valid), .inc(inc), .d(redirect_pc), .pc(pc)
  );
  assign pc_next = redirect_valid ? redirect_pc : pc;
  assign imem_req = (state == WAIT) || (state == DRAIN);
  assign imem_addr = req_addr;
  always_comb begin
    state_n = state;
    addr_n = req_addr;
    valid_n = if_valid;
    instr_n = if_instr;
    ipc_n = if_pc;
    inc = 1'b0;
    case (state)
      IDLE: begin
        state_n = WAIT;
        addr_n = pc_next;
      end
      WAIT:
        if (redirect_valid) begin
          state_n = imem_ack ? WAIT : DRAIN;
          addr_n = imem_ack ? redirect_pc : req_addr;
        end else if (imem_ack) begin
          state_n = FULL;
          instr_n = imem_rdata;
          ipc_n = req_addr;
          valid_n = 1'b1;
          inc = 1'b1;
        end
      DRAIN:
        if (imem_ack) begin
          state_n = WAIT;
          addr_n = pc_next;
        end
      FULL:
        if (redirect_valid || id_ready) begin
          state_n = WAIT;
          valid_n = 1'b0;
          addr_n = pc_next;
        end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      req_addr <= '0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
    end else begin
      state <= state_n;
      req_addr <= addr_n;
      if_valid <= valid_n;
      if_instr <= instr_n;
      if_pc <= ipc_n;
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan steps plus randomized run against a program-flow scoreboard
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_ack, mem_ack = 1'b0, inj_ack = 1'b0;
  logic [7:0] imem_addr, if_pc, redirect_pc = '0;
  logic [15:0] imem_rdata = '0, if_instr;
  logic if_valid, id_ready = 1'b1, redirect_valid = 1'b0;
  int checks = 0, errors = 0, lat = 1, cnt = 0, n;
  logic ps_req = 1'b0, ps_ack = 1'b0;
  logic [7:0] ps_addr = '0;
  assign imem_ack = mem_ack | inj_ack;
  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  // memory: ack arrives lat cycles after the first cycle imem_req is seen high
  initial forever begin
    @(negedge clk);
    if (imem_req) begin
      cnt++;
      mem_ack = cnt >= lat + 1;
      if (mem_ack) begin
        imem_rdata = 16'h1000 + 16'(imem_addr);
        cnt = 0;
      end
    end else begin
      cnt = 0;
      mem_ack = 1'b0;
    end
  end
  initial forever begin
    @(posedge clk);
    ps_req = imem_req;
    ps_ack = imem_ack;
    ps_addr = imem_addr;
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int c);
    c = 0;
    while (!if_valid && c < 50) begin
      tick();
      c++;
    end
    if (!if_valid) chk("timeout_valid", if_valid, 1);
  endtask
  task automatic next_valid(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (!if_valid && c < 50);
    if (!if_valid) chk("timeout_valid", if_valid, 1);
  endtask
  initial begin
    logic [7:0] exp_pc;
    logic rv;
    int idle;
    repeat (3) tick();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);
    rst = 1'b0;
    tick();
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) wait_valid(n);
      else next_valid(n);
      chk("t1_spacing", n, k == 0 ? 2 : 3);
      chk("t1_pc", if_pc, k);
      chk("t1_instr", if_instr, 16'h1000 + k);
    end
    next_valid(n);
    chk("t2_pc", if_pc, 3);
    id_ready = 1'b0;
    repeat (5) begin
      tick();
      chk("t2_valid", if_valid, 1);
      chk("t2_pc_hold", if_pc, 3);
      chk("t2_instr_hold", if_instr, 16'h1003);
      chk("t2_req", imem_req, 0);
    end
    id_ready = 1'b1;
    tick();
    chk("t2_req_after", imem_req, 1);
    chk("t2_addr_after", imem_addr, 4);
    wait_valid(n);
    chk("t3_pc_before", if_pc, 4);
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flush", if_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 8'h40);
    wait_valid(n);
    chk("t3_pc", if_pc, 8'h40);
    chk("t3_instr", if_instr, 16'h1040);
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 8'h05;
    tick();
    chk("t4_addr5", imem_addr, 5);
    redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_drain_addr", imem_addr, 5);
      chk("t4_drain_req", imem_req, 1);
      chk("t4_drain_valid", if_valid, 0);
      tick();
    end
    chk("t4_new_addr", imem_addr, 8'h20);
    chk("t4_new_valid", if_valid, 0);
    wait_valid(n);
    chk("t4_pc", if_pc, 8'h20);
    chk("t4_instr", if_instr, 16'h1020);
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    wait_valid(n);
    chk("t5_pc_ff", if_pc, 8'hFF);
    chk("t5_instr_ff", if_instr, 16'h10FF);
    next_valid(n);
    chk("t5_pc_00", if_pc, 8'h00);
    chk("t5_instr_00", if_instr, 16'h1000);
    next_valid(n);
    chk("t5_pc_01", if_pc, 8'h01);
    tick();
    chk("t6_wait_req", imem_req, 1);
    chk("t6_wait_addr", imem_addr, 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_valid", if_valid, 0);
    tick();
    rst = 1'b0;
    inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    chk("t6_valid", if_valid, 0);
    chk("t6_req", imem_req, 1);
    chk("t6_addr", imem_addr, 0);
    wait_valid(n);
    chk("t6_pc", if_pc, 0);
    chk("t6_instr", if_instr, 16'h1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 8'h00;
    rv = 1'b0;
    idle = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (rv) chk("r_flush", if_valid, 0);
      if (if_valid) begin
        chk("r_pc", if_pc, exp_pc);
        chk("r_instr", if_instr, 16'h1000 + 16'(if_pc));
        idle = 0;
      end else if (++idle > 60) begin
        chk("r_progress", if_valid, 1);
        idle = 0;
      end
      if (ps_req && !ps_ack) chk("r_addr_hold", {imem_req, imem_addr}, {1'b1, ps_addr});
      rv = $urandom_range(15) == 0;
      redirect_valid = rv;
      redirect_pc = 8'($urandom);
      id_ready = $urandom_range(3) != 0;
      if ($urandom_range(31) == 0) lat = $urandom_range(1, 3);
      if (if_valid && id_ready && !rv) exp_pc = exp_pc + 8'd1;
      if (rv) exp_pc = redirect_pc;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
